// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//   Shares one AXI4 master write path between two burst-writing requesters.
//   AW is arbitrated per burst, round-robin between S0 and S1. Each accepted
//   AW pushes the winner's index into a grant-order FIFO. W beats are steered
//   from the requester at the FIFO head, and the head is popped on WLAST.
//   The winner's index is prepended to M_AWID. B responses are routed back
//   using that top ID bit. W and B are purely combinational muxes.
//
// Ports (n = 0,1)
//   clk, reset                  single clock, synchronous active-high reset
//   Sn_AW*  / Sn_AWVALID/READY  requester n write-address channel
//   Sn_W*   / Sn_WVALID/READY   requester n write-data channel
//   Sn_B*   / Sn_BVALID/READY   requester n write-response channel
//   M_AW*   / M_AWVALID/READY   shared master write-address channel
//                               (M_AWID = {grant, Sn_AWID})
//   M_W*    / M_WVALID/READY    shared master write-data channel
//   M_B*    / M_BVALID/READY    shared master write-response channel
module axi_wr_arbiter #(
  parameter int IW         = 2,
  parameter int AW         = 20,
  parameter int DW         = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic [AW-1:0]     S0_AWADDR,
  input  logic [7:0]        S0_AWLEN,
  input  logic [2:0]        S0_AWSIZE,
  input  logic [1:0]        S0_AWBURST,
  input  logic [IW-1:0]     S0_AWID,
  input  logic              S0_AWVALID,
  output logic              S0_AWREADY,
  input  logic [DW-1:0]     S0_WDATA,
  input  logic [DW/8-1:0]   S0_WSTRB,
  input  logic              S0_WLAST,
  input  logic              S0_WVALID,
  output logic              S0_WREADY,
  output logic [1:0]        S0_BRESP,
  output logic [IW-1:0]     S0_BID,
  output logic              S0_BVALID,
  input  logic              S0_BREADY,
  // requester 1
  input  logic [AW-1:0]     S1_AWADDR,
  input  logic [7:0]        S1_AWLEN,
  input  logic [2:0]        S1_AWSIZE,
  input  logic [1:0]        S1_AWBURST,
  input  logic [IW-1:0]     S1_AWID,
  input  logic              S1_AWVALID,
  output logic              S1_AWREADY,
  input  logic [DW-1:0]     S1_WDATA,
  input  logic [DW/8-1:0]   S1_WSTRB,
  input  logic              S1_WLAST,
  input  logic              S1_WVALID,
  output logic              S1_WREADY,
  output logic [1:0]        S1_BRESP,
  output logic [IW-1:0]     S1_BID,
  output logic              S1_BVALID,
  input  logic              S1_BREADY,
  // master
  output logic [AW-1:0]     M_AWADDR,
  output logic [7:0]        M_AWLEN,
  output logic [2:0]        M_AWSIZE,
  output logic [1:0]        M_AWBURST,
  output logic [IW:0]       M_AWID,
  output logic              M_AWLOCK,
  output logic [3:0]        M_AWCACHE,
  output logic [3:0]        M_AWQOS,
  output logic [2:0]        M_AWPROT,
  output logic              M_AWVALID,
  input  logic              M_AWREADY,
  output logic [DW-1:0]     M_WDATA,
  output logic [DW/8-1:0]   M_WSTRB,
  output logic              M_WLAST,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  input  logic [1:0]        M_BRESP,
  input  logic [IW:0]       M_BID,
  input  logic              M_BVALID,
  output logic              M_BREADY
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_last,  w_last_nxt;
  logic          w_push, w_pop;
  logic          w_sel_awvalid, w_awvalid;

  logic          r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          w_full, w_nempty, w_head;
  logic          w_head_wvalid, w_wvalid;
  logic          w_bsel;

  assign w_full   = (r_count == CNT_FULL);
  assign w_nempty = (r_count != '0);
  assign w_head   = r_fifo[r_rptr];

  // ---------------- AW arbitration ----------------
  assign w_sel_awvalid = r_grant ? S1_AWVALID : S0_AWVALID;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_push      = 1'b0;
    w_awvalid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_full && (S0_AWVALID || S1_AWVALID)) begin
          if (S0_AWVALID && S1_AWVALID) w_grant_nxt = ~r_last;
          else                          w_grant_nxt = S1_AWVALID;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_awvalid = w_sel_awvalid;
        if (w_sel_awvalid && M_AWREADY) begin
          w_push      = 1'b1;
          w_last_nxt  = r_grant;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign M_AWVALID  = ~reset & w_awvalid;
  assign S0_AWREADY = ~reset & (r_state == ST_GRANT) & ~r_grant & M_AWREADY;
  assign S1_AWREADY = ~reset & (r_state == ST_GRANT) &  r_grant & M_AWREADY;

  assign M_AWADDR  = r_grant ? S1_AWADDR  : S0_AWADDR;
  assign M_AWLEN   = r_grant ? S1_AWLEN   : S0_AWLEN;
  assign M_AWSIZE  = r_grant ? S1_AWSIZE  : S0_AWSIZE;
  assign M_AWBURST = r_grant ? S1_AWBURST : S0_AWBURST;
  assign M_AWID    = {r_grant, (r_grant ? S1_AWID : S0_AWID)};
  assign M_AWLOCK  = 1'b0;
  assign M_AWCACHE = '0;
  assign M_AWQOS   = '0;
  assign M_AWPROT  = '0;

  // ---------------- grant-order FIFO ----------------
  // Push and pop may coincide; the count only moves when exactly one happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_fifo[r_wptr] <= r_grant;
  end

  // ---------------- W steering ----------------
  assign w_head_wvalid = w_head ? S1_WVALID : S0_WVALID;
  assign w_wvalid      = ~reset & w_nempty & w_head_wvalid;

  assign M_WVALID  = w_wvalid;
  assign M_WDATA   = w_head ? S1_WDATA : S0_WDATA;
  assign M_WSTRB   = w_head ? S1_WSTRB : S0_WSTRB;
  assign M_WLAST   = w_head ? S1_WLAST : S0_WLAST;
  assign S0_WREADY = ~reset & w_nempty & ~w_head & M_WREADY;
  assign S1_WREADY = ~reset & w_nempty &  w_head & M_WREADY;

  assign w_pop = w_wvalid & M_WREADY & M_WLAST;

  // ---------------- B routing ----------------
  assign w_bsel    = M_BID[IW];
  assign S0_BVALID = ~reset & ~w_bsel & M_BVALID;
  assign S1_BVALID = ~reset &  w_bsel & M_BVALID;
  assign S0_BID    = M_BID[IW-1:0];
  assign S1_BID    = M_BID[IW-1:0];
  assign S0_BRESP  = M_BRESP;
  assign S1_BRESP  = M_BRESP;
  assign M_BREADY  = ~reset & (w_bsel ? S1_BREADY : S0_BREADY);

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-port AXI4 write-channel arbiter that shares a single AXI4 master write path (into the BRAM/HSI memory) between two burst-writing requesters such as fill engines. Arbitration is per burst on the AW channel with round-robin fairness. A grant-order FIFO steers W beats in AW order. B responses are routed back by an ID bit the arbiter prepends. The read channel is outside this block.

## Interface
Parameters:
- IW, 2, requester ID width; master ID width is IW+1
- AW, 20, address width
- DW, 512, data width; strobe width DW/8
- FIFO_DEPTH, 4, outstanding AW-accepted bursts whose W data is not yet complete (power of 2, ≥2)

Ports (n = 0,1):
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- Sn_AWADDR/AWLEN/AWSIZE/AWBURST/AWID  in  AW/8/3/2/IW  requester n write-address fields
- Sn_AWVALID  in  1 / Sn_AWREADY  out  1  requester n AW handshake
- Sn_WDATA/WSTRB/WLAST  in  DW/DW/8/1  requester n write data
- Sn_WVALID  in  1 / Sn_WREADY  out  1  requester n W handshake
- Sn_BRESP/BID  out  2/IW  response to requester n
- Sn_BVALID  out  1 / Sn_BREADY  in  1  requester n B handshake
- M_AWADDR/AWLEN/AWSIZE/AWBURST  out  AW/8/3/2  muxed from granted requester
- M_AWID  out  IW+1  {grant index, Sn_AWID}
- M_AWLOCK/AWCACHE/AWQOS/AWPROT  out  1/4/4/3  constant 0
- M_AWVALID  out  1 / M_AWREADY  in  1
- M_WDATA/WSTRB/WLAST  out  DW/DW/8/1  muxed from FIFO-head requester
- M_WVALID  out  1 / M_WREADY  in  1
- M_BRESP/BID  in  2/IW+1 ; M_BVALID  in  1 / M_BREADY  out  1

## Operation
- AW state machine, states IDLE and GRANT. Registers: grant (1 bit), last (1 bit, last winner).
- IDLE: if FIFO not full and any Sn_AWVALID, register grant as follows, then go to GRANT. Both requesting: grant = ~last. One requesting: grant = that one.
- GRANT: M_AWVALID = S[grant]_AWVALID (held high by the requester per AXI). M_AW* fields come from S[grant]. S[grant]_AWREADY = M_AWREADY. The other requester's AWREADY = 0.
- On M_AWVALID & M_AWREADY: push grant into the order FIFO, last <= grant, go to IDLE.
- Grant never changes in GRANT state, so AW fields stay stable while valid.
- W path (combinational off the FIFO head h):
  - FIFO non-empty: M_WVALID = S[h]_WVALID; S[h]_WREADY = M_WREADY; other WREADY = 0.
  - FIFO empty: M_WVALID = 0 and both WREADY = 0.
- On M_WVALID & M_WREADY & M_WLAST: pop the FIFO.
- Simultaneous push and pop: both take effect; count unchanged. A push when full cannot occur because IDLE blocks new grants when full.
- B path: r = M_BID[IW]. Sr_BVALID = M_BVALID; Sr_BID = M_BID[IW-1:0]; Sr_BRESP = M_BRESP; M_BREADY = Sr_BREADY. The other BVALID = 0.
- Beat counts are not checked; WLAST alone terminates a burst.

## Timing
- Reset: state IDLE, last = 1 (so S0 wins the first tie), FIFO empty, grant = 0.
- While reset is high, force 0 on M_AWVALID, M_WVALID, M_BREADY, both Sn_AWREADY, both Sn_WREADY, and both Sn_BVALID.
- Reset mid-burst abandons the burst. Requesters are reset on the same signal.
- AW latency: Sn_AWVALID seen at edge k → grant registered → M_AWVALID high from cycle k+1. The handshake completes at the earliest at the edge ending cycle k+1.
- After an AW handshake, IDLE takes 1 cycle, so the minimum AW-to-AW spacing is 2 cycles.
- A burst's W beats can pass no earlier than the cycle after its AW handshake; requesters holding WVALID earlier simply wait.
- W and B paths add zero latency (pure mux, no registers).
- Throughput: back-to-back W bursts from different requesters with no bubble when the FIFO holds both grants.

## Test plan
- S0 alone, AWADDR 0x000, AWLEN 3, AWID 1 →
  - M_AWID 3'b001.
  - 4 W beats pass with WLAST on the 4th.
  - FIFO empty after.
  - M_BID 3'b001 → S0_BVALID with S0_BID 1, S1_BVALID 0.
- S0 and S1 both assert AWVALID at the same edge after reset →
  - S0 granted first, then S1.
  - Held contention with both requesters continuously requesting → grants alternate S0, S1, S0, S1.
- M_WREADY held 0, both requesters issuing AWs →
  - Exactly 4 AW handshakes, then M_AWVALID stays 0 while the FIFO is full.
  - Releasing WREADY drains W in AW order, and AW resumes one cycle after the first pop.
- S1 AW granted while S0 holds WVALID → S0_WREADY stays 0 until its own AW is accepted and at the FIFO head.
- M_BID 3'b110 with S1_BREADY 0 for 3 cycles → S1_BVALID 1 with S1_BID 2'b10, M_BREADY 0 until S1_BREADY rises.
- Reset asserted mid-burst (beat 2 of 4) →
  - Next cycle: all valid/ready outputs 0, FIFO empty.
  - After release, a tie grants S0 first.
